mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates single-ported main memory between the instruction cache miss path and the data cache miss/writeback path.
- Sits between both caches and MainMemory.
- Serializes one word access at a time, using a round-robin choice between the two requesters.
- Sequences memory read/write strobes for a fixed access latency, then returns a one-cycle ready pulse to the granted requester.

Parameters:
- MEM_LATENCY, 4: cycles the memory strobe is held per access; legal values are 1 or more.
- ADDR_W, 32: address width.
- DATA_W, 32: data word width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  icache request; held high until i_ready
- i_addr  in  ADDR_W  icache read address
- i_ready  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  DATA_W  read data to icache
- d_req  in  1  dcache request; held high until d_ready
- d_write  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  DATA_W  dcache write data
- d_ready  out  1  one-cycle pulse; access done, d_rdata valid on reads
- d_rdata  out  DATA_W  read data to dcache
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, latency counter 0, last_grant = ICACHE.
- States:
  - IDLE: sample i_req and d_req.
    - Only i_req high: grant I.
    - Only d_req high: grant D.
    - Both high: grant the requester that is not last_grant.
    - On a grant: latch addr, wdata, op and owner; update last_grant; load counter = MEM_LATENCY-1; go to ACCESS.
    - The icache op is always a read.
  - ACCESS:
    - mem_addr and mem_wdata drive the latched values.
    - mem_read = op is read; mem_write = op is write.
    - Both strobes stay stable for exactly MEM_LATENCY cycles.
    - When counter = 0: capture mem_rdata (reads only), drop strobes, go to RESP. Otherwise decrement the counter.
  - RESP:
    - Owner's ready = 1 for exactly one cycle; owner's rdata = captured word.
    - On writes, rdata holds its previous value.
    - Next state is IDLE.
- Timing: request seen in IDLE at cycle 0 → strobes in cycles 1..MEM_LATENCY → ready in cycle MEM_LATENCY+1.
  - Next grant is no earlier than MEM_LATENCY+2.
  - Back-to-back accesses cost MEM_LATENCY+2 cycles each.
- Requester rules:
  - Hold req, addr, wdata and write constant from assertion until its ready pulse.
  - Deassert req at the clock edge that samples ready, unless issuing a new request.
  - Request inputs are ignored outside IDLE. Changes during ACCESS/RESP have no effect, because values are latched at grant.
- Never more than one ready high per cycle; never both mem_read and mem_write high.
- rdata outputs persist until that requester's next read completes.
- A request arriving while the other requester is being served waits. It is granted in the first IDLE cycle after RESP.
  - If both requesters are then pending, round-robin applies: the waiter wins because it was not last_grant.
- Reset during ACCESS or RESP:
  - At the reset edge, strobes and ready go to 0 and state goes to IDLE.
  - The pending access is dropped with no ready pulse.
  - Requesters must reissue after reset.

Test Plan:
- icache read, addr 0x40, mem model returns 0xDEADBEEF, MEM_LATENCY=4 → mem_read high in cycles 1-4 with mem_addr=0x40; i_ready pulses in cycle 5 with i_rdata=0xDEADBEEF; d_ready stays 0.
- dcache write of 0x12345678 to 0x80, then dcache read of 0x80 → mem_write high for 4 cycles with correct addr and data; d_ready pulses; the read returns d_rdata=0x12345678.
- i_req and d_req both rise in the same IDLE cycle after reset → D is granted first (mem_addr = d_addr). I is granted in the IDLE cycle after d_ready, with i_ready 6 cycles after d_ready.
- Both requesters reissue immediately for 6 accesses → grants alternate D, I, D, I, D, I; every response lands exactly 6 cycles apart.
- d_req asserts in cycle 2 of an icache access → i_ready at cycle 5; D granted at cycle 6; d_ready at cycle 11.
- rst asserted in cycle 3 of a dcache write → at the next cycle all strobes and readys are 0; no d_ready; a fresh i_req is served with the normal latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the icache and dcache miss paths one word access each to single-ported memory.
// Strobes are held MEM_LATENCY cycles, then the owner gets a one-cycle ready; requesters hold their request until that pulse.
module mem_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWNER_I, OWNER_D} owner_t;

  state_t            state, stateNext;
  owner_t            owner, ownerNext;
  owner_t            lastGrant, lastGrantNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] wdataNext;
  logic [DATA_W-1:0] iRdataNext, dRdataNext;
  logic              readNext, writeNext;
  logic              iReadyNext, dReadyNext;
  logic              grantD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWNER_I;
      lastGrant <= OWNER_I;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      lastGrant <= lastGrantNext;
      cnt       <= cntNext;
      mem_addr  <= addrNext;
      mem_wdata <= wdataNext;
      mem_read  <= readNext;
      mem_write <= writeNext;
      i_ready   <= iReadyNext;
      d_ready   <= dReadyNext;
      i_rdata   <= iRdataNext;
      d_rdata   <= dRdataNext;
    end
  end

  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    lastGrantNext = lastGrant;
    cntNext       = cnt;
    addrNext      = mem_addr;
    wdataNext     = mem_wdata;
    readNext      = mem_read;
    writeNext     = mem_write;
    iReadyNext    = 1'b0;
    dReadyNext    = 1'b0;
    iRdataNext    = i_rdata;
    dRdataNext    = d_rdata;
    // On a tie the dcache wins unless it was the last one served.
    grantD        = d_req && (!i_req || (lastGrant == OWNER_I));

    case (state)
      IDLE: begin
        if (grantD) begin
          addrNext      = d_addr;
          wdataNext     = d_wdata;
          readNext      = !d_write;
          writeNext     = d_write;
          ownerNext     = OWNER_D;
          lastGrantNext = OWNER_D;
          cntNext       = CNT_LOAD;
          stateNext     = ACCESS;
        end else if (i_req) begin
          addrNext      = i_addr;
          readNext      = 1'b1;
          writeNext     = 1'b0;
          ownerNext     = OWNER_I;
          lastGrantNext = OWNER_I;
          cntNext       = CNT_LOAD;
          stateNext     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          readNext  = 1'b0;
          writeNext = 1'b0;
          stateNext = RESP;
          if (owner == OWNER_D) begin
            dReadyNext = 1'b1;
            if (mem_read) dRdataNext = mem_rdata;
          end else begin
            iReadyNext = 1'b1;
            iRdataNext = mem_rdata;
          end
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

endmodule
